// File: rtl/pc_fetch_unit.sv
// Program-counter stage of the single-cycle MIPS core: holds the PC, picks the
// next PC (sequential/branch/jump/jr), counts retired instructions, detects halt/fault.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 32,
   parameter int          CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic [15:0]      imm,
   input  logic [25:0]      addr,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic             fault
);

   typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

   // One bit wider than the PC so that a 4 GiB memory size cannot overflow.
   localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             halted_q, halted_d;
   logic             fault_q, fault_d;

   logic [31:0]      next_pc;
   logic [31:0]      branch_target;
   logic             branch_taken;
   logic             next_illegal;

   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
   assign branch_taken  = ((op == OP_BEQ) && (rs_data == rt_data)) ||
                          ((op == OP_BNE) && (rs_data != rt_data));

   always_comb begin
      next_pc = pc_plus4;
      if ((op == OP_RTYPE) && (func == FN_JR)) begin
         next_pc = rs_data;
      end else if ((op == OP_J) || (op == OP_JAL)) begin
         next_pc = {pc_plus4[31:28], addr, 2'b00};
      end else if (branch_taken) begin
         next_pc = branch_target;
      end
   end

   assign next_illegal = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= IMEM_BYTES);

   // Only the selected next_pc is checked, so a not-taken branch to an
   // illegal target never faults.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      if ((state_q == S_RUN) && !stall) begin
         if (next_pc == pc_q) begin
            state_d   = S_HALT;
            retired_d = retired_q + CNT_W'(1);
         end else if (next_illegal) begin
            state_d   = S_FAULT;
         end else begin
            pc_d      = next_pc;
            retired_d = retired_q + CNT_W'(1);
         end
      end
      halted_d = (state_d == S_HALT);
      fault_d  = (state_d == S_FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         pc_q      <= RESET_PC;
         retired_q <= '0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
         halted_q  <= halted_d;
         fault_q   <= fault_d;
      end
   end

   assign pc      = pc_q;
   assign retired = retired_q;
   assign halted  = halted_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table for the main flow plus
// hand-written sequences for fault, asynchronous reset and stall-vs-halt.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [5:0]  op;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [25:0] addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
   logic [31:0] retired;
   logic [1:0]  retired_b;
   logic        halted, fault, halted_b, fault_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .func(func), .imm(imm),
      .addr(addr), .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
      .pc_plus4(pc_plus4), .retired(retired), .halted(halted), .fault(fault)
   );

   // Narrow counter copy sharing all inputs, used to observe counter wrap.
   pc_fetch_unit #(.CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .func(func), .imm(imm),
      .addr(addr), .rs_data(rs_data), .rt_data(rt_data), .pc(pc_b),
      .pc_plus4(pc_plus4_b), .retired(retired_b), .halted(halted_b), .fault(fault_b)
   );

   typedef struct {
      logic        st;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] addr;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pp4;
      logic [31:0] pc;
      logic [31:0] ret;
      logic        h;
      logic        f;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [5:0] o, input logic [5:0] fn,
                        input logic [15:0] im, input logic [25:0] ad,
                        input logic [31:0] rs, input logic [31:0] rt);
      stall = st; op = o; func = fn; imm = im; addr = ad; rs_data = rs; rt_data = rt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] eret,
                            input logic eh, input logic ef);
      chk({tag, " pc"}, pc, epc);
      chk({tag, " retired"}, retired, eret);
      chk({tag, " halted"}, {31'd0, halted}, {31'd0, eh});
      chk({tag, " fault"}, {31'd0, fault}, {31'd0, ef});
   endtask

   task automatic do_reset();
      drive(1'b0, 6'h08, 6'h00, 16'h0, 26'h0, 32'h0, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_state("reset", 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      // st  op     fn     imm       addr     rs      rt     pp4    pc     ret  h  f
      vq.push_back('{0, 6'h08, 6'h00, 16'h0000, 26'h00, 32'h0,  32'h0, 32'h04, 32'h04, 1, 0, 0});
      vq.push_back('{0, 6'h08, 6'h00, 16'h0000, 26'h00, 32'h0,  32'h0, 32'h08, 32'h08, 2, 0, 0});
      vq.push_back('{0, 6'h08, 6'h00, 16'h0000, 26'h00, 32'h0,  32'h0, 32'h0C, 32'h0C, 3, 0, 0});
      vq.push_back('{0, 6'h03, 6'h00, 16'h0000, 26'h18, 32'h0,  32'h0, 32'h10, 32'h60, 4, 0, 0});
      vq.push_back('{0, 6'h00, 6'h08, 16'h0000, 26'h00, 32'h10, 32'h0, 32'h64, 32'h10, 5, 0, 0});
      vq.push_back('{0, 6'h02, 6'h00, 16'h0000, 26'h1D, 32'h0,  32'h0, 32'h14, 32'h74, 6, 0, 0});
      vq.push_back('{0, 6'h05, 6'h00, 16'hFFFB, 26'h00, 32'h3,  32'h0, 32'h78, 32'h64, 7, 0, 0});
      vq.push_back('{0, 6'h02, 6'h00, 16'h0000, 26'h1D, 32'h0,  32'h0, 32'h68, 32'h74, 8, 0, 0});
      vq.push_back('{0, 6'h05, 6'h00, 16'hFFFB, 26'h00, 32'h0,  32'h0, 32'h78, 32'h78, 9, 0, 0});
      vq.push_back('{0, 6'h02, 6'h00, 16'h0000, 26'h1D, 32'h0,  32'h0, 32'h7C, 32'h74, 10, 0, 0});
      vq.push_back('{0, 6'h04, 6'h00, 16'hFFFB, 26'h00, 32'h3,  32'h0, 32'h78, 32'h78, 11, 0, 0});
      vq.push_back('{0, 6'h02, 6'h00, 16'h0000, 26'h1D, 32'h0,  32'h0, 32'h7C, 32'h74, 12, 0, 0});
      vq.push_back('{0, 6'h04, 6'h00, 16'hFFFB, 26'h00, 32'h0,  32'h0, 32'h78, 32'h64, 13, 0, 0});
      for (int i = 0; i < 4; i++)
         vq.push_back('{1, 6'h04, 6'h00, 16'hFFFB, 26'h00, 32'h0, 32'h0, 32'h68, 32'h64, 13, 0, 0});
      vq.push_back('{0, 6'h04, 6'h00, 16'hFFFB, 26'h00, 32'h0,  32'h0, 32'h68, 32'h54, 14, 0, 0});
      vq.push_back('{0, 6'h05, 6'h00, 16'h7FFF, 26'h00, 32'h5,  32'h5, 32'h58, 32'h58, 15, 0, 0});
      vq.push_back('{0, 6'h08, 6'h00, 16'h0000, 26'h00, 32'h0,  32'h0, 32'h5C, 32'h5C, 16, 0, 0});
      vq.push_back('{0, 6'h02, 6'h00, 16'h0000, 26'h17, 32'h0,  32'h0, 32'h60, 32'h5C, 17, 1, 0});
      vq.push_back('{0, 6'h00, 6'h08, 16'h0000, 26'h00, 32'h10, 32'h0, 32'h60, 32'h5C, 17, 1, 0});
      vq.push_back('{0, 6'h08, 6'h00, 16'h0000, 26'h00, 32'h0,  32'h0, 32'h60, 32'h5C, 17, 1, 0});
      vq.push_back('{1, 6'h02, 6'h00, 16'h0000, 26'h00, 32'h0,  32'h0, 32'h60, 32'h5C, 17, 1, 0});

      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vq[i].st, vq[i].op, vq[i].fn, vq[i].imm, vq[i].addr, vq[i].rs, vq[i].rt);
         #1;
         chk({tag, " pc_plus4"}, pc_plus4, vq[i].pp4);
         step();
         chk_state(tag, vq[i].pc, vq[i].ret, vq[i].h, vq[i].f);
         chk({tag, " retired_w"}, {30'd0, retired_b}, {30'd0, vq[i].ret[1:0]});
         $display("%s: op=%h st=%0d pc=%h retired=%0d halted=%0b fault=%0b",
                  tag, vq[i].op, vq[i].st, pc, retired, halted, fault);
      end

      // Last legal word, then first word past the end of memory.
      do_reset();
      drive(1'b0, 6'h00, 6'h08, 16'h0, 26'h0, 32'h7C, 32'h0);
      step();
      chk_state("jr_last", 32'h7C, 32'h1, 1'b0, 1'b0);
      drive(1'b0, 6'h00, 6'h08, 16'h0, 26'h0, 32'h80, 32'h0);
      step();
      chk_state("jr_oob", 32'h7C, 32'h1, 1'b0, 1'b1);
      drive(1'b0, 6'h08, 6'h00, 16'h0, 26'h0, 32'h0, 32'h0);
      step();
      chk_state("fault_abs", 32'h7C, 32'h1, 1'b0, 1'b1);
      $display("seq boundary: pc=%h fault=%0b", pc, fault);

      do_reset();
      drive(1'b0, 6'h00, 6'h08, 16'h0, 26'h0, 32'h200, 32'h0);
      step();
      chk_state("jr_200", 32'h0, 32'h0, 1'b0, 1'b1);
      $display("seq jr 0x200: pc=%h fault=%0b", pc, fault);

      // Misaligned jr, then an asynchronous reset between clock edges.
      do_reset();
      drive(1'b0, 6'h08, 6'h00, 16'h0, 26'h0, 32'h0, 32'h0);
      step();
      drive(1'b0, 6'h00, 6'h08, 16'h0, 26'h0, 32'h12, 32'h0);
      step();
      chk_state("jr_mis", 32'h4, 32'h1, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
      $display("seq async reset: pc=%h fault=%0b", pc, fault);

      // Stall wins over a pending halt; jr to self halts once released.
      do_reset();
      drive(1'b1, 6'h00, 6'h08, 16'h0, 26'h0, 32'h0, 32'h0);
      step();
      chk_state("stall_halt", 32'h0, 32'h0, 1'b0, 1'b0);
      stall = 1'b0;
      step();
      chk_state("jr_self", 32'h0, 32'h1, 1'b1, 1'b0);
      $display("seq stall/halt: pc=%h retired=%0d halted=%0b", pc, retired, halted);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
